// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, FSM state encoding and op-class helper shared by the ALU top and its iterative unit.
package alu_pkg;
    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_AND   = 4'd2;
    localparam logic [3:0] ALU_OR    = 4'd3;
    localparam logic [3:0] ALU_XOR   = 4'd4;
    localparam logic [3:0] ALU_SLT   = 4'd5;
    localparam logic [3:0] ALU_SLTU  = 4'd6;
    localparam logic [3:0] ALU_SLL   = 4'd7;
    localparam logic [3:0] ALU_SRL   = 4'd8;
    localparam logic [3:0] ALU_SRA   = 4'd9;
    localparam logic [3:0] ALU_MUL   = 4'd10;
    localparam logic [3:0] ALU_MULHU = 4'd11;
    localparam logic [3:0] ALU_DIVU  = 4'd12;
    localparam logic [3:0] ALU_REMU  = 4'd13;

    typedef enum logic {ST_IDLE, ST_ITER} state_t;

    function automatic logic is_iter(input logic [3:0] op);
        return (op == ALU_MUL) || (op == ALU_MULHU) || (op == ALU_DIVU) || (op == ALU_REMU);
    endfunction
endpackage

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: radix-2 shift-add multiply / restoring divide, one bit per clock over DATA_W clocks.
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              flush,
    input  logic              ack,
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] res,
    output logic              dz
);
    localparam int CNT_W = $clog2(DATA_W) + 1;

    logic              busy_q, busy_d, div_q, div_d, hi_sel_q, hi_sel_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d, m_q, m_d;
    logic [DATA_W-1:0] src_hi, src_lo, rem_nx;
    logic [DATA_W:0]   mul_sum, div_sh;
    logic              op_div, op_hi, div_ok, step;

    assign op_div = (op == ALU_DIVU) || (op == ALU_REMU);
    assign op_hi  = (op == ALU_MULHU) || (op == ALU_REMU);
    assign busy   = busy_q;
    assign done   = busy_q && (cnt_q == '0);
    assign res    = hi_sel_q ? hi_q : lo_q;
    assign dz     = div_q && (m_q == '0);

    // The start cycle already performs the first iteration on the raw operands,
    // so done rises DATA_W clocks after start.
    always_comb begin
        src_hi   = start ? '0 : hi_q;
        src_lo   = start ? (op_div ? a : b) : lo_q;
        m_d      = start ? (op_div ? b : a) : m_q;
        div_d    = start ? op_div : div_q;
        hi_sel_d = start ? op_hi : hi_sel_q;
        mul_sum  = {1'b0, src_hi} + {1'b0, (src_lo[0] ? m_d : {DATA_W{1'b0}})};
        div_sh   = {src_hi, src_lo[DATA_W-1]};
        div_ok   = div_sh >= {1'b0, m_d};
        rem_nx   = div_ok ? DATA_W'(div_sh - {1'b0, m_d}) : div_sh[DATA_W-1:0];
        step     = start || (busy_q && (cnt_q != '0));
        hi_d     = !step ? hi_q : div_d ? rem_nx : mul_sum[DATA_W:1];
        lo_d     = !step ? lo_q : div_d ? {src_lo[DATA_W-2:0], div_ok} : {mul_sum[0], src_lo[DATA_W-1:1]};
        cnt_d    = start ? CNT_W'(DATA_W - 1) : step ? cnt_q - CNT_W'(1) : cnt_q;
        busy_d   = flush ? 1'b0 : start ? 1'b1 : (done && ack) ? 1'b0 : busy_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q   <= 1'b0;
            div_q    <= 1'b0;
            hi_sel_q <= 1'b0;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            m_q      <= '0;
        end else begin
            busy_q   <= busy_d;
            div_q    <= div_d;
            hi_sel_q <= hi_sel_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            m_q      <= m_d;
        end
    end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU; single-cycle ops registered directly, MUL/DIV delegated to alu_muldiv_iter.
module alu_seq
    import alu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [TAG_W-1:0]  in_tag,
    input  logic              abort,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_res,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_ovf,
    output logic              out_dz,
    output logic              out_ill
);
    localparam int SH_W = $clog2(DATA_W);

    state_t            state_q, state_d;
    logic [TAG_W-1:0]  tag_q, tag_d, out_tag_q, out_tag_d;
    logic [DATA_W-1:0] out_res_q, out_res_d, alu_res, sum, diff, md_res;
    logic              out_valid_q, out_valid_d, out_ovf_q, out_ovf_d, out_dz_q, out_dz_d, out_ill_q, out_ill_d;
    logic              alu_ovf, alu_ill, out_free, accept, md_start, iter_ack, md_load;
    logic              md_busy, md_done, md_dz;
    logic [SH_W-1:0]   sh;

    assign out_free = !out_valid_q || out_ready;
    assign in_ready = (state_q == ST_IDLE) && !md_busy && out_free;
    assign accept   = in_valid && in_ready && !abort;
    assign md_start = accept && is_iter(in_op);
    assign iter_ack = (state_q == ST_ITER) && out_free;
    assign md_load  = iter_ack && md_done;
    assign sh       = in_b[SH_W-1:0];
    assign sum      = in_a + in_b;
    assign diff     = in_a - in_b;

    assign out_valid = out_valid_q;
    assign out_res   = out_res_q;
    assign out_tag   = out_tag_q;
    assign out_ovf   = out_ovf_q;
    assign out_dz    = out_dz_q;
    assign out_ill   = out_ill_q;

    alu_muldiv_iter #(.DATA_W(DATA_W)) u_md (
        .clk   (clk),
        .rst   (rst),
        .start (md_start),
        .flush (abort),
        .ack   (iter_ack),
        .op    (in_op),
        .a     (in_a),
        .b     (in_b),
        .busy  (md_busy),
        .done  (md_done),
        .res   (md_res),
        .dz    (md_dz)
    );

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        alu_ill = 1'b0;
        case (in_op)
            ALU_ADD: begin
                alu_res = sum;
                alu_ovf = (in_a[DATA_W-1] == in_b[DATA_W-1]) && (sum[DATA_W-1] != in_a[DATA_W-1]);
            end
            ALU_SUB: begin
                alu_res = diff;
                alu_ovf = (in_a[DATA_W-1] != in_b[DATA_W-1]) && (diff[DATA_W-1] != in_a[DATA_W-1]);
            end
            ALU_AND:  alu_res = in_a & in_b;
            ALU_OR:   alu_res = in_a | in_b;
            ALU_XOR:  alu_res = in_a ^ in_b;
            ALU_SLT:  alu_res = DATA_W'($signed(in_a) < $signed(in_b));
            ALU_SLTU: alu_res = DATA_W'(in_a < in_b);
            ALU_SLL:  alu_res = in_a << sh;
            ALU_SRL:  alu_res = in_a >> sh;
            ALU_SRA:  alu_res = $signed(in_a) >>> sh;
            ALU_MUL, ALU_MULHU, ALU_DIVU, ALU_REMU: alu_res = '0;
            default:  alu_ill = 1'b1;
        endcase
    end

    // Priority: abort, then a new accept, then completion of the iterative unit.
    always_comb begin
        state_d     = state_q;
        tag_d       = tag_q;
        out_valid_d = out_valid_q && !out_ready;
        out_res_d   = out_res_q;
        out_tag_d   = out_tag_q;
        out_ovf_d   = out_ovf_q;
        out_dz_d    = out_dz_q;
        out_ill_d   = out_ill_q;
        if (abort) begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
        end else if (md_start) begin
            state_d = ST_ITER;
            tag_d   = in_tag;
        end else if (accept) begin
            out_valid_d = 1'b1;
            out_res_d   = alu_res;
            out_tag_d   = in_tag;
            out_ovf_d   = alu_ovf;
            out_dz_d    = 1'b0;
            out_ill_d   = alu_ill;
        end else if (md_load) begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b1;
            out_res_d   = md_res;
            out_tag_d   = tag_q;
            out_ovf_d   = 1'b0;
            out_dz_d    = md_dz;
            out_ill_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            tag_q       <= '0;
            out_valid_q <= 1'b0;
            out_res_q   <= '0;
            out_tag_q   <= '0;
            out_ovf_q   <= 1'b0;
            out_dz_q    <= 1'b0;
            out_ill_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            tag_q       <= tag_d;
            out_valid_q <= out_valid_d;
            out_res_q   <= out_res_d;
            out_tag_q   <= out_tag_d;
            out_ovf_q   <= out_ovf_d;
            out_dz_q    <= out_dz_d;
            out_ill_q   <= out_ill_d;
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed scenarios plus randomized traffic scored against an arithmetic reference model.
module tb_alu_seq;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid, in_ready, abort, out_valid, out_ready, out_ovf, out_dz, out_ill;
    logic [3:0]  in_op, in_tag, out_tag;
    logic [31:0] in_a, in_b, out_res;

    int n_tests = 0;
    int n_fail  = 0;

    logic [38:0] q[$];
    logic [38:0] e;

    logic [3:0]  t4_op [4] = '{ALU_DIVU, ALU_REMU, ALU_DIVU, ALU_REMU};
    logic [31:0] t4_b  [4] = '{32'd0, 32'd0, 32'd7, 32'd7};
    logic [31:0] t4_res[4] = '{32'hFFFFFFFF, 32'd100, 32'd14, 32'd2};
    logic        t4_dz [4] = '{1'b1, 1'b1, 1'b0, 1'b0};

    always #5 clk = ~clk;

    alu_seq #(.DATA_W(32), .TAG_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_tag    (in_tag),
        .abort     (abort),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .out_tag   (out_tag),
        .out_ovf   (out_ovf),
        .out_dz    (out_dz),
        .out_ill   (out_ill)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Returns {tag, ovf, dz, ill, res}.
    function automatic logic [38:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] tag);
        logic [31:0] r;
        logic [63:0] p;
        logic        ovf, dz, ill;
        longint      s;
        r = 0;
        ovf = 0;
        dz = 0;
        ill = 0;
        p = {32'b0, a} * {32'b0, b};
        case (op)
            ALU_ADD: begin
                r = a + b;
                s = longint'($signed(a)) + longint'($signed(b));
                ovf = s != longint'($signed(r));
            end
            ALU_SUB: begin
                r = a - b;
                s = longint'($signed(a)) - longint'($signed(b));
                ovf = s != longint'($signed(r));
            end
            ALU_AND:   r = a & b;
            ALU_OR:    r = a | b;
            ALU_XOR:   r = a ^ b;
            ALU_SLT:   r = ($signed(a) < $signed(b)) ? 1 : 0;
            ALU_SLTU:  r = (a < b) ? 1 : 0;
            ALU_SLL:   r = a << b[4:0];
            ALU_SRL:   r = a >> b[4:0];
            ALU_SRA:   r = $signed(a) >>> b[4:0];
            ALU_MUL:   r = p[31:0];
            ALU_MULHU: r = p[63:32];
            ALU_DIVU: begin
                r = (b == 0) ? 32'hFFFFFFFF : a / b;
                dz = (b == 0);
            end
            ALU_REMU: begin
                r = (b == 0) ? a : a % b;
                dz = (b == 0);
            end
            default:   ill = 1;
        endcase
        return {tag, ovf, dz, ill, r};
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'($urandom_range(1, 40));
            2:       return 32'h7FFFFFFF;
            3:       return 32'h80000000;
            default: return $urandom;
        endcase
    endfunction

    // Scoreboard: inputs change at posedge+1, so the negedge sees exactly what the next edge will act on.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
        end else begin
            if (out_valid && q.size() == 0) begin
                chk("spurious_valid", 64'(out_valid), 64'd0);
            end else if (out_valid && out_ready) begin
                e = q.pop_front();
                chk("res", 64'(out_res), 64'(e[31:0]));
                chk("tag_flags", 64'({out_tag, out_ovf, out_dz, out_ill}), 64'(e[38:32]));
            end
            if (abort) q.delete();
            else if (in_valid && in_ready) q.push_back(model(in_op, in_a, in_b, in_tag));
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
        int n;
        n = 0;
        in_valid = 1;
        in_op = op;
        in_a = a;
        in_b = b;
        in_tag = tag;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (n >= 100) chk("send_timeout", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 0;
    endtask

    task automatic wait_out(output int lat, output logic rdy);
        lat = 1;
        rdy = 0;
        while (!out_valid && lat < 100) begin
            rdy |= in_ready;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   lat;
        logic rdy, seen, stable;
        logic [31:0] held;
        in_valid = 0;
        in_op = 0;
        in_a = 0;
        in_b = 0;
        in_tag = 0;
        abort = 0;
        out_ready = 1;
        idle(3);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_res", 64'(out_res), 64'd0);
        chk("rst_tag_flags", 64'({out_tag, out_ovf, out_dz, out_ill}), 64'd0);
        rst = 0;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        send(ALU_ADD, 32'h7FFFFFFF, 32'd1, 4'd3);
        chk("t1_valid", 64'(out_valid), 64'd1);
        chk("t1_res", 64'(out_res), 64'h80000000);
        chk("t1_ovf", 64'(out_ovf), 64'd1);
        chk("t1_tag", 64'(out_tag), 64'd3);

        for (int i = 0; i < 10; i++) begin
            send(ALU_XOR, $urandom, $urandom, 4'(i));
            chk("t2_valid", 64'(out_valid), 64'd1);
            chk("t2_tag", 64'(out_tag), 64'(i));
        end

        send(ALU_MUL, 32'h0000FFFF, 32'h00010001, 4'd5);
        wait_out(lat, rdy);
        chk("t3_latency", 64'(lat), 64'd33);
        chk("t3_ready_in_iter", 64'(rdy), 64'd0);
        chk("t3_res", 64'(out_res), 64'hFFFFFFFF);

        for (int i = 0; i < 4; i++) begin
            send(t4_op[i], 32'd100, t4_b[i], 4'(i + 6));
            wait_out(lat, rdy);
            chk("t4_latency", 64'(lat), 64'd33);
            chk("t4_res", 64'(out_res), 64'(t4_res[i]));
            chk("t4_dz", 64'(out_dz), 64'(t4_dz[i]));
        end

        idle(2);
        out_ready = 0;
        send(ALU_SUB, 32'd5, 32'd7, 4'd9);
        chk("t5_res", 64'(out_res), 64'hFFFFFFFE);
        held = out_res;
        stable = 1;
        rdy = 0;
        repeat (5) begin
            idle(1);
            if (out_res !== held || !out_valid) stable = 0;
            rdy |= in_ready;
        end
        chk("t5_stable", 64'(stable), 64'd1);
        chk("t5_in_ready_low", 64'(rdy), 64'd0);
        out_ready = 1;
        idle(1);
        chk("t5_single_handshake", 64'(out_valid), 64'd0);

        send(ALU_DIVU, 32'd1000, 32'd3, 4'd1);
        idle(9);
        abort = 1;
        idle(1);
        abort = 0;
        seen = 0;
        repeat (40) begin
            seen |= out_valid;
            idle(1);
        end
        chk("t6_abort_no_valid", 64'(seen), 64'd0);
        chk("t6_abort_ready", 64'(in_ready), 64'd1);
        send(ALU_MUL, 32'd7, 32'd9, 4'd2);
        idle(5);
        #2 rst = 1;
        idle(1);
        rst = 0;
        seen = 0;
        repeat (40) begin
            seen |= out_valid;
            idle(1);
        end
        chk("t6_reset_no_valid", 64'(seen), 64'd0);
        send(ALU_ADD, 32'd2, 32'd2, 4'd4);
        chk("t6_add_valid", 64'(out_valid), 64'd1);
        chk("t6_add_res", 64'(out_res), 64'd4);

        for (int c = 0; c < 1500; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_op     = 4'($urandom_range(0, 15));
            in_a      = pick();
            in_b      = pick();
            in_tag    = 4'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            abort     = ($urandom_range(0, 99) == 0);
            idle(1);
        end
        in_valid = 0;
        abort = 0;
        out_ready = 1;
        idle(40);
        chk("drain_empty", 64'(q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
